// File: rtl/cbfp_pingpong_norm.sv
// cbfp_pingpong_norm: convergent block-floating-point normaliser.
// Buffers blocks of BLK_BEATS beats x LANES complex samples in a two-bank
// ping-pong store. It finds each block's peak magnitude bit and re-emits the
// block so that the peak lands on bit OUT_W-2. The applied shift is reported
// as a per-block exponent.
// Ports:
//   clk, rst_n                 clock (rising edge) / async active-low reset
//   in_valid/in_ready          input beat handshake
//   in_re, in_im               LANES signed IN_W samples per beat
//   bypass                     sampled on the first beat of a block; forces exponent 0
//   out_valid/out_ready        output beat handshake
//   out_re, out_im             LANES signed OUT_W normalised samples
//   out_exp_re, out_exp_im     signed shift applied (left positive), constant per block
//   out_last                   final beat of each block
module cbfp_pingpong_norm #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 13,
  parameter int LANES     = 16,
  parameter int BLK_BEATS = 4,
  parameter int EXP_W     = 6,
  parameter int SEP_RE_IM = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][IN_W-1:0]   in_re,
  input  logic [LANES-1:0][IN_W-1:0]   in_im,
  input  logic                         bypass,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0][OUT_W-1:0]  out_re,
  output logic [LANES-1:0][OUT_W-1:0]  out_im,
  output logic [EXP_W-1:0]             out_exp_re,
  output logic [EXP_W-1:0]             out_exp_im,
  output logic                         out_last
);
  localparam int PW = $clog2(IN_W);
  localparam int BW = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
  localparam int WW = IN_W + OUT_W + 2;
  localparam logic signed [WW-1:0] SMAX = (WW'(1) <<< (OUT_W - 1)) - WW'(1);
  localparam logic signed [WW-1:0] SMIN = -SMAX - WW'(1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_st_t;

  // Highest set bit of |x|, |x| taken as IN_W-bit unsigned; msb(0) = 0.
  function automatic logic [PW-1:0] msb_of(input logic [IN_W-1:0] x);
    logic [IN_W-1:0] a;
    msb_of = '0;
    a = x[IN_W-1] ? (~x + 1'b1) : x;
    for (int unsigned i = 0; i < IN_W; i++)
      if (a[i]) msb_of = PW'(i);
  endfunction

  // Shift left by sh, or round-half-up right shift by -sh; then saturate.
  function automatic logic [OUT_W-1:0] norm(input logic [IN_W-1:0] x,
                                            input logic signed [EXP_W-1:0] sh);
    logic signed [WW-1:0] v, r, half;
    logic [EXP_W-1:0] n;
    v = WW'($signed(x));
    if (!sh[EXP_W-1]) begin
      n = sh;
      r = v <<< n;
    end else begin
      n = -sh;
      half = WW'(1) <<< (n - 1'b1);
      r = (v + half) >>> n;
    end
    if (r > SMAX)      norm = SMAX[OUT_W-1:0];
    else if (r < SMIN) norm = SMIN[OUT_W-1:0];
    else               norm = r[OUT_W-1:0];
  endfunction

  logic [LANES-1:0][IN_W-1:0] mem_re [2][BLK_BEATS];
  logic [LANES-1:0][IN_W-1:0] mem_im [2][BLK_BEATS];

  bank_st_t bank_q [2];
  bank_st_t bank_d [2];
  rd_st_t rd_st_q, rd_st_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [BW-1:0] wr_beat_q, wr_beat_d, rd_beat_q, rd_beat_d;
  logic [PW-1:0] pk_re_q, pk_re_d, pk_im_q, pk_im_d;
  logic byp_q, byp_d, in_ready_q, in_ready_d;
  logic signed [EXP_W-1:0] sh_re_q [2];
  logic signed [EXP_W-1:0] sh_im_q [2];
  logic [LANES-1:0][OUT_W-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [EXP_W-1:0] exp_re_q, exp_re_d, exp_im_q, exp_im_d;
  logic out_last_q, out_last_d;

  logic acc, first, wr_fin, byp_eff, out_v;
  logic [PW-1:0] bpk_re, bpk_im, m, pr, pi;
  logic signed [EXP_W-1:0] sh_re_now, sh_im_now, sh_re_src, sh_im_src;
  logic nxt_bank, slot_free, src_full, src_fin, load, hs_last;
  logic [BW-1:0] nxt_beat;

  assign out_v = (rd_st_q == R_DRAIN);

  always_comb begin
    acc     = in_valid && in_ready_q;
    first   = (wr_beat_q == '0);
    wr_fin  = acc && (wr_beat_q == BW'(BLK_BEATS - 1));
    bpk_re  = '0;
    bpk_im  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      m = msb_of(in_re[l]);
      if (m > bpk_re) bpk_re = m;
      m = msb_of(in_im[l]);
      if (m > bpk_im) bpk_im = m;
    end
    pk_re_d = (first || pk_re_q < bpk_re) ? bpk_re : pk_re_q;
    pk_im_d = (first || pk_im_q < bpk_im) ? bpk_im : pk_im_q;
    if (SEP_RE_IM != 0) begin
      pr = pk_re_d;
      pi = pk_im_d;
    end else begin
      pr = (pk_re_d > pk_im_d) ? pk_re_d : pk_im_d;
      pi = pr;
    end
    byp_eff   = first ? bypass : byp_q;
    byp_d     = (acc && first) ? bypass : byp_q;
    sh_re_now = byp_eff ? '0 : EXP_W'(OUT_W - 2) - EXP_W'(pr);
    sh_im_now = byp_eff ? '0 : EXP_W'(OUT_W - 2) - EXP_W'(pi);
    if (!acc) begin
      pk_re_d = pk_re_q;
      pk_im_d = pk_im_q;
    end
    wr_beat_d = acc ? (wr_fin ? '0 : wr_beat_q + 1'b1) : wr_beat_q;
    wr_bank_d = wr_fin ? ~wr_bank_q : wr_bank_q;

    // The output register is the only read stage; the next beat to load is
    // derived from what it currently holds. A bank whose last beat is being
    // written this cycle is readable at once (its shift is taken from the
    // live peak), which gives out_valid the cycle after the final input beat.
    nxt_bank  = (out_v && out_last_q) ? ~rd_bank_q : rd_bank_q;
    nxt_beat  = (out_v && !out_last_q) ? rd_beat_q + 1'b1 : '0;
    slot_free = !out_v || out_ready;
    src_full  = (bank_q[nxt_bank] == B_FULL);
    src_fin   = wr_fin && (wr_bank_q == nxt_bank);
    load      = slot_free && (src_full || src_fin);
    sh_re_src = src_full ? sh_re_q[nxt_bank] : sh_re_now;
    sh_im_src = src_full ? sh_im_q[nxt_bank] : sh_im_now;
    hs_last   = out_v && out_ready && out_last_q;

    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    if (acc && first) bank_d[wr_bank_q] = B_FILLING;
    if (wr_fin)       bank_d[wr_bank_q] = B_FULL;
    if (hs_last)      bank_d[rd_bank_q] = B_EMPTY;
    in_ready_d = (bank_d[wr_bank_d] != B_FULL);
    rd_bank_d  = hs_last ? ~rd_bank_q : rd_bank_q;

    rd_st_d    = rd_st_q;
    rd_beat_d  = rd_beat_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;
    exp_re_d   = exp_re_q;
    exp_im_d   = exp_im_q;
    out_last_d = out_last_q;
    if (load) begin
      rd_st_d    = R_DRAIN;
      rd_beat_d  = nxt_beat;
      out_last_d = (nxt_beat == BW'(BLK_BEATS - 1));
      exp_re_d   = sh_re_src;
      exp_im_d   = sh_im_src;
      for (int unsigned l = 0; l < LANES; l++) begin
        out_re_d[l] = norm(mem_re[nxt_bank][nxt_beat][l], sh_re_src);
        out_im_d[l] = norm(mem_im[nxt_bank][nxt_beat][l], sh_im_src);
      end
    end else if (slot_free) begin
      rd_st_d    = R_IDLE;
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      mem_re[wr_bank_q][wr_beat_q] <= in_re;
      mem_im[wr_bank_q][wr_beat_q] <= in_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]  <= B_EMPTY;
      bank_q[1]  <= B_EMPTY;
      sh_re_q[0] <= '0;
      sh_re_q[1] <= '0;
      sh_im_q[0] <= '0;
      sh_im_q[1] <= '0;
      rd_st_q    <= R_IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_beat_q  <= '0;
      rd_beat_q  <= '0;
      pk_re_q    <= '0;
      pk_im_q    <= '0;
      byp_q      <= 1'b0;
      in_ready_q <= 1'b1;
      out_re_q   <= '0;
      out_im_q   <= '0;
      exp_re_q   <= '0;
      exp_im_q   <= '0;
      out_last_q <= 1'b0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      if (wr_fin) begin
        sh_re_q[wr_bank_q] <= sh_re_now;
        sh_im_q[wr_bank_q] <= sh_im_now;
      end
      rd_st_q    <= rd_st_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_beat_q  <= wr_beat_d;
      rd_beat_q  <= rd_beat_d;
      pk_re_q    <= pk_re_d;
      pk_im_q    <= pk_im_d;
      byp_q      <= byp_d;
      in_ready_q <= in_ready_d;
      out_re_q   <= out_re_d;
      out_im_q   <= out_im_d;
      exp_re_q   <= exp_re_d;
      exp_im_q   <= exp_im_d;
      out_last_q <= out_last_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_v;
  assign out_re     = out_re_q;
  assign out_im     = out_im_q;
  assign out_exp_re = exp_re_q;
  assign out_exp_im = exp_im_q;
  assign out_last   = out_last_q;
endmodule

// File: tb/tb_cbfp_pingpong_norm.sv
// Testbench for cbfp_pingpong_norm: drives a shared-exponent instance and a
// separate-re/im instance with identical input streams. Both are checked
// against a block-level reference model.
module tb_cbfp_pingpong_norm;
  localparam int IN_W = 16, OUT_W = 13, LANES = 16, BLK = 4, EXP_W = 6;

  typedef struct packed {
    logic [LANES-1:0][IN_W-1:0] re, im;
    logic byp;
  } beat_t;
  typedef struct packed {
    logic [LANES-1:0][OUT_W-1:0] re, im;
    logic [EXP_W-1:0] er, ei;
    logic last;
  } exp_t;

  logic clk = 0, rst_n = 1, in_valid = 0, bypass = 0, out_ready = 1;
  logic [LANES-1:0][IN_W-1:0] in_re = '0, in_im = '0;
  logic in_ready, out_valid, out_last, in_ready_s, out_valid_s, out_last_s;
  logic [LANES-1:0][OUT_W-1:0] out_re, out_im, out_re_s, out_im_s;
  logic [EXP_W-1:0] out_exp_re, out_exp_im, out_exp_re_s, out_exp_im_s;

  always #5 clk = ~clk;

  cbfp_pingpong_norm #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .BLK_BEATS(BLK),
                       .EXP_W(EXP_W), .SEP_RE_IM(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .bypass(bypass), .out_valid(out_valid),
    .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_exp_re(out_exp_re), .out_exp_im(out_exp_im), .out_last(out_last));

  cbfp_pingpong_norm #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .BLK_BEATS(BLK),
                       .EXP_W(EXP_W), .SEP_RE_IM(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_re(in_re), .in_im(in_im), .bypass(bypass), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_re(out_re_s), .out_im(out_im_s),
    .out_exp_re(out_exp_re_s), .out_exp_im(out_exp_im_s), .out_last(out_last_s));

  int ncmp = 0, nfail = 0, cyc = 0, full_blocks = 0;
  int last_acc_cyc = 0, rise_cyc = 0, acc_cnt = 0, cur_n = 0;
  bit gap_mode = 0, rand_rdy = 0, hold = 0, prev_v = 0, cur_byp = 0;
  logic [EXP_W-1:0] rise_er, rise_s_er, rise_s_ei;
  logic [OUT_W-1:0] rise_re0, rise_s_im0;
  int cur_re [BLK][LANES];
  int cur_im [BLK][LANES];
  beat_t stim[$];
  exp_t q0[$], q1[$];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int msb_m(input int x);
    int a = (x < 0) ? -x : x;
    int r = 0;
    for (int b = 0; b <= IN_W; b++) if (a >= (1 << b)) r = b;
    return r;
  endfunction

  function automatic int norm_m(input int x, input int sh);
    int y;
    if (sh >= 0) y = x * (1 << sh);
    else y = (x + (1 << (-sh - 1))) >>> (-sh);
    if (y > (1 << (OUT_W - 1)) - 1) y = (1 << (OUT_W - 1)) - 1;
    if (y < -(1 << (OUT_W - 1))) y = -(1 << (OUT_W - 1));
    return y;
  endfunction

  // Completed input block -> expected output beats for both instances.
  task automatic model_block();
    int pr = 0, pi = 0, shr, shi;
    exp_t e;
    for (int b = 0; b < BLK; b++)
      for (int l = 0; l < LANES; l++) begin
        if (msb_m(cur_re[b][l]) > pr) pr = msb_m(cur_re[b][l]);
        if (msb_m(cur_im[b][l]) > pi) pi = msb_m(cur_im[b][l]);
      end
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        shr = OUT_W - 2 - ((pr > pi) ? pr : pi);
        shi = shr;
      end else begin
        shr = OUT_W - 2 - pr;
        shi = OUT_W - 2 - pi;
      end
      if (cur_byp) begin shr = 0; shi = 0; end
      for (int b = 0; b < BLK; b++) begin
        for (int l = 0; l < LANES; l++) begin
          e.re[l] = OUT_W'(norm_m(cur_re[b][l], shr));
          e.im[l] = OUT_W'(norm_m(cur_im[b][l], shi));
        end
        e.er = EXP_W'(shr);
        e.ei = EXP_W'(shi);
        e.last = (b == BLK - 1);
        if (s == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  task automatic mon(input int s, input logic v, input logic [LANES-1:0][OUT_W-1:0] re,
                     input logic [LANES-1:0][OUT_W-1:0] im, input logic [EXP_W-1:0] er,
                     input logic [EXP_W-1:0] ei, input logic last);
    exp_t e;
    int sz = (s == 0) ? q0.size() : q1.size();
    if (v) begin
      ncmp++;
      assert (sz > 0) else begin
        nfail++;
        $error("FAIL dut%0d_spurious_valid got valid=1 exp no pending beat", s);
      end
      if (sz > 0) begin
        e = (s == 0) ? q0[0] : q1[0];
        chk($sformatf("dut%0d_re", s), re, e.re);
        chk($sformatf("dut%0d_im", s), im, e.im);
        chk($sformatf("dut%0d_exp_re", s), er, e.er);
        chk($sformatf("dut%0d_exp_im", s), ei, e.ei);
        chk($sformatf("dut%0d_last", s), last, e.last);
        if (out_ready) begin
          if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  task automatic drive();
    if (hold) out_ready = 0;
    else if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1;
    if (stim.size() > 0 && (!gap_mode || $urandom_range(0, 4) != 0)) begin
      in_valid = 1;
      in_re = stim[0].re;
      in_im = stim[0].im;
      bypass = stim[0].byp;
    end else begin
      in_valid = 0;
      bypass = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step();
    logic acc, hs_last0;
    @(negedge clk);
    cyc++;
    acc = in_valid & in_ready;
    chk("in_ready", in_ready, full_blocks < 2);
    chk("in_ready_s", in_ready_s, full_blocks < 2);
    hs_last0 = out_valid && out_ready && q0.size() > 0 && q0[0].last;
    mon(0, out_valid, out_re, out_im, out_exp_re, out_exp_im, out_last);
    mon(1, out_valid_s, out_re_s, out_im_s, out_exp_re_s, out_exp_im_s, out_last_s);
    if (out_valid && !prev_v) begin
      rise_cyc = cyc;
      rise_er = out_exp_re;
      rise_re0 = out_re[0];
      rise_s_er = out_exp_re_s;
      rise_s_ei = out_exp_im_s;
      rise_s_im0 = out_im_s[0];
    end
    prev_v = out_valid;
    if (acc) begin
      acc_cnt++;
      last_acc_cyc = cyc;
      if (cur_n == 0) cur_byp = bypass;
      for (int l = 0; l < LANES; l++) begin
        cur_re[cur_n][l] = int'($signed(in_re[l]));
        cur_im[cur_n][l] = int'($signed(in_im[l]));
      end
      cur_n++;
      if (cur_n == BLK) begin
        model_block();
        full_blocks++;
        cur_n = 0;
      end
    end
    if (hs_last0) full_blocks--;
    @(posedge clk);
    #1;
    if (acc) void'(stim.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_n = 0;
    in_valid = 0;
    stim.delete(); q0.delete(); q1.delete();
    cur_n = 0; full_blocks = 0; prev_v = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_valid_s", out_valid_s, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im_s", out_im_s, 0);
    chk("rst_exp", {out_exp_re, out_exp_im}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1;
    drive();
  endtask

  // mode 0 random scaled, 1 const 0x0100, 2 extremes, 3 split re/im peaks, 4 zeros
  task automatic push_block(input int mode, input bit byp);
    beat_t bt;
    int k;
    for (int b = 0; b < BLK; b++) begin
      k = $urandom_range(0, 15);
      for (int l = 0; l < LANES; l++) begin
        case (mode)
          1: begin bt.re[l] = 16'h0100; bt.im[l] = '0; end
          2: begin
            bt.re[l] = 16'($urandom_range(0, 2000)) - 16'd1000;
            bt.im[l] = 16'($urandom_range(0, 2000)) - 16'd1000;
          end
          3: begin
            bt.re[l] = 16'($urandom_range(0, 30)) - 16'd15;
            bt.im[l] = 16'($urandom_range(0, 8190)) - 16'd4095;
          end
          4: begin bt.re[l] = '0; bt.im[l] = '0; end
          default: begin
            bt.re[l] = 16'($signed(16'($urandom)) >>> k);
            bt.im[l] = 16'($signed(16'($urandom)) >>> k);
          end
        endcase
      end
      if (b == 0 && mode == 2) begin bt.re[0] = 16'h8000; bt.re[1] = 16'h7fff; end
      if (b == 0 && mode == 3) begin bt.re[0] = 16'd15; bt.im[0] = 16'h1001; end
      bt.byp = (b == 0) ? byp : 1'($urandom_range(0, 1));
      stim.push_back(bt);
    end
  endtask

  task automatic drain();
    int n = 0;
    drive();
    while ((stim.size() > 0 || q0.size() > 0 || q1.size() > 0) && n < 3000) begin
      step();
      n++;
    end
    chk("drain_pending", stim.size() + q0.size() + q1.size(), 0);
  endtask

  initial begin
    #3;
    do_reset();

    push_block(1, 0);
    drain();
    chk("t1_latency", rise_cyc, last_acc_cyc + 1);
    chk("t1_exp", rise_er, 6'd3);
    chk("t1_re0", rise_re0, 13'h0800);

    push_block(2, 0);
    drain();
    chk("t2_exp", rise_er, 6'h3C);
    chk("t2_re0", rise_re0, 13'h1800);

    push_block(3, 0);
    drain();
    chk("t3_sep_exp_re", rise_s_er, 6'd8);
    chk("t3_sep_exp_im", rise_s_ei, 6'h3F);
    chk("t3_sep_im0", rise_s_im0, 13'h0801);
    chk("t3_shared_exp", rise_er, 6'h3F);

    hold = 1;
    out_ready = 0;
    push_block(0, 0); push_block(0, 0); push_block(0, 0);
    acc_cnt = 0;
    drive();
    repeat (12) step();
    chk("bp_accepted", acc_cnt, 8);
    chk("bp_in_ready", in_ready, 0);
    hold = 0;
    drain();

    push_block(0, 1);
    drain();
    chk("t5_bypass_exp", rise_er, 6'd0);
    push_block(4, 0);
    drain();
    chk("t5_zero_exp", rise_er, 6'd11);

    hold = 1;
    push_block(0, 0); push_block(0, 0);
    drive();
    repeat (6) step();
    hold = 0;
    do_reset();
    push_block(0, 0);
    drain();

    gap_mode = 1;
    rand_rdy = 1;
    for (int i = 0; i < 24; i++)
      push_block((i % 6 == 5) ? 2 : ((i % 8 == 7) ? 4 : 0), $urandom_range(0, 3) == 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
